// File: rtl/amp_gain_sequencer_pkg.sv
// Shared types and helpers for the amplifier gain-code sequencer:
// FSM state encoding, default configuration and target-slice extraction.
package amp_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RAMP,
        S_SETTLE,
        S_ACK
    } state_t;

    localparam int DEF_NREQ     = 4;
    localparam int DEF_GW       = 4;
    localparam int DEF_RAMP_DIV = 2;
    localparam int DEF_SETTLE   = 8;

    // Generic carrier widths so one helper serves every NREQ/GW combination.
    localparam int MAX_BUS = 256;
    localparam int MAX_GW  = 32;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [MAX_GW-1:0] tgt_slice(input logic [MAX_BUS-1:0] packed_tgt,
                                                    input int idx,
                                                    input int gw);
        logic [MAX_BUS-1:0] mask;
        mask = ~({MAX_BUS{1'b1}} << gw);
        return MAX_GW'((packed_tgt >> (idx * gw)) & mask);
    endfunction

endpackage

// File: rtl/amp_gain_sequencer_if.sv
// Requester/amplifier-side bundle of the gain sequencer; the sequencer is the
// slave (consumes requests, drives the gain code), the stimulus side is the master.
interface amp_gain_sequencer_if import amp_seq_pkg::*;
    #(parameter int NREQ = DEF_NREQ,
      parameter int GW   = DEF_GW);

    logic [NREQ-1:0]    req;
    logic [NREQ*GW-1:0] tgt;
    logic [GW-1:0]      gain_code;
    logic               step;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    ack;
    logic               busy;

    modport master (output req, tgt, input gain_code, step, grant, ack, busy);
    modport slave  (input req, tgt, output gain_code, step, grant, ack, busy);

endinterface

// File: rtl/amp_gain_sequencer_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above the pointer,
// wrapping around, reported both one-hot and as an index.
module rr_arbiter import amp_seq_pkg::*;
    #(parameter int NREQ = DEF_NREQ,
      localparam int IW = cnt_width(NREQ))
    (input  logic [NREQ-1:0] req,
     input  logic [IW-1:0]   pointer,
     input  logic            enable,
     output logic [NREQ-1:0] winner,
     output logic [IW-1:0]   index);

    // Scan from the far end back toward the pointer so the closest hit wins.
    always_comb begin
        int j;
        j      = 0;
        winner = '0;
        index  = '0;
        if (enable) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                j = (int'(pointer) + k) % NREQ;
                if (req[j]) begin
                    winner    = '0;
                    winner[j] = 1'b1;
                    index     = IW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/amp_gain_sequencer.sv
// Owns the Amp gain code: arbitrates requesters round-robin, ramps the code one
// LSB per RAMP_DIV cycles toward the winner's target, settles, then acknowledges.
module amp_gain_sequencer import amp_seq_pkg::*;
    #(parameter int NREQ       = DEF_NREQ,
      parameter int GW         = DEF_GW,
      parameter int RAMP_DIV   = DEF_RAMP_DIV,
      parameter int SETTLE     = DEF_SETTLE,
      parameter int RESET_CODE = 0)
    (input logic clk,
     input logic rst,
     amp_gain_sequencer_if.slave bus);

    localparam int IW = cnt_width(NREQ);
    localparam int DW = cnt_width(RAMP_DIV);
    localparam int SW = cnt_width(SETTLE);

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   arb_idx;
    logic [NREQ-1:0] arb_onehot;
    logic [NREQ-1:0] win_onehot;
    logic [GW-1:0]   code_q;
    logic [GW-1:0]   code_next;
    logic [GW-1:0]   target;
    logic [GW-1:0]   sel_tgt;
    logic [DW-1:0]   div;
    logic [SW-1:0]   settle_cnt;
    logic            step_now;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (bus.req),
        .pointer (ptr),
        .enable  (state == S_IDLE),
        .winner  (arb_onehot),
        .index   (arb_idx)
    );

    assign sel_tgt = GW'(tgt_slice(MAX_BUS'(bus.tgt), int'(arb_idx), GW));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        step_now   = 1'b0;
        code_next  = code_q;
        case (state)
            S_IDLE:   if (|bus.req) state_next = S_RAMP;
            S_RAMP: begin
                if (code_q == target) begin
                    state_next = S_SETTLE;
                end else if (div == DW'(RAMP_DIV - 1)) begin
                    step_now  = 1'b1;
                    code_next = (target > code_q) ? code_q + GW'(1) : code_q - GW'(1);
                end
            end
            S_SETTLE: if (settle_cnt == '0) state_next = S_ACK;
            S_ACK:    state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Winner, target and divider are captured only in IDLE, so later tgt/req
    // changes cannot disturb a service already in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            win_onehot <= '0;
            target     <= GW'(RESET_CODE);
            code_q     <= GW'(RESET_CODE);
            div        <= '0;
            settle_cnt <= '0;
        end else begin
            code_q <= code_next;
            case (state)
                S_IDLE: begin
                    if (|bus.req) begin
                        win_onehot <= arb_onehot;
                        target     <= sel_tgt;
                        ptr        <= (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
                        div        <= '0;
                    end
                end
                S_RAMP: begin
                    if (code_q == target)                settle_cnt <= SW'(SETTLE - 1);
                    else if (div == DW'(RAMP_DIV - 1))   div <= '0;
                    else                                 div <= div + DW'(1);
                end
                S_SETTLE: if (settle_cnt != '0) settle_cnt <= settle_cnt - SW'(1);
                default: ;
            endcase
        end
    end

    // The code is presented in the cycle the step is taken, so step and the new
    // code value line up on the same cycle.
    assign bus.gain_code = code_next;
    assign bus.step      = step_now;
    assign bus.busy      = (state != S_IDLE);
    assign bus.grant     = (state == S_RAMP || state == S_SETTLE) ? win_onehot : '0;
    assign bus.ack       = (state == S_ACK) ? win_onehot : '0;

endmodule

// File: tb/tb_amp_gain_sequencer.sv
// Scoreboard bench: a transaction-level model predicts each service (winner,
// latch cycle, ack cycle, code trajectory); a monitor checks every cycle.
module tb_amp_gain_sequencer;
    import amp_seq_pkg::*;

    localparam int NREQ = 4;
    localparam int GW   = 4;
    localparam int RD   = 2;
    localparam int ST   = 8;
    localparam int RC   = 0;

    typedef struct {
        int winner;
        int start;
        int target;
        int latch;
        int ack;
    } svc_t;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic rst_q = 1'b1;
    int   cyc   = 0;

    int checks   = 0;
    int failures = 0;

    svc_t sb[$];
    int   ack_log[$];
    int   last_code = RC;

    logic [NREQ-1:0] req_v = '0;
    int  tgt_v[NREQ];
    bit  pend[NREQ];
    int  ack_at[NREQ];
    bit  sticky = 1'b0;
    int  m_ptr  = 0;
    int  m_code = RC;
    int  m_free = 0;
    int  rr_exp[5] = '{0, 1, 2, 3, 0};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    amp_gain_sequencer_if #(.NREQ(NREQ), .GW(GW)) ifc ();

    amp_gain_sequencer #(
        .NREQ(NREQ), .GW(GW), .RAMP_DIV(RD), .SETTLE(ST), .RESET_CODE(RC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic drive();
        logic [NREQ*GW-1:0] t;
        t = '0;
        for (int i = 0; i < NREQ; i++) t[i*GW +: GW] = GW'(tgt_v[i]);
        ifc.req = req_v;
        ifc.tgt = t;
    endtask

    // One service per IDLE visit: duration follows from the distance to travel.
    task automatic model_cycle();
        int w;
        int d;
        int a;
        bit found;
        if (rst) begin
            m_ptr  = 0;
            m_code = RC;
            m_free = cyc + 1;
            return;
        end
        if (cyc >= m_free && req_v != '0) begin
            found = 1'b0;
            w = 0;
            for (int k = 0; k < NREQ; k++) begin
                if (!found && req_v[(m_ptr + k) % NREQ]) begin
                    found = 1'b1;
                    w = (m_ptr + k) % NREQ;
                end
            end
            d = (tgt_v[w] > m_code) ? tgt_v[w] - m_code : m_code - tgt_v[w];
            a = cyc + 2 + d * RD + ST;
            sb.push_back('{winner: w, start: m_code, target: tgt_v[w], latch: cyc, ack: a});
            m_code    = tgt_v[w];
            m_ptr     = (w + 1) % NREQ;
            m_free    = a + 1;
            ack_at[w] = a;
        end
    endtask

    task automatic applyStimulus(input int idx, input int code);
        req_v[idx] = 1'b1;
        tgt_v[idx] = code;
        pend[idx]  = 1'b1;
    endtask

    task automatic step_cycle(input bit random_en);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (ack_at[i] == cyc) begin
                ack_at[i] = -1;
                if (!sticky) begin
                    pend[i]  = 1'b0;
                    req_v[i] = 1'b0;
                end
            end
        end
        if (random_en) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 7) == 0)
                        applyStimulus(i, int'($urandom_range(0, 2**GW - 1)));
                end else if (ack_at[i] >= 0) begin
                    if ($urandom_range(0, 15) == 0) begin
                        req_v[i] = 1'b0;
                        tgt_v[i] = int'($urandom_range(0, 2**GW - 1));
                    end
                end else if ($urandom_range(0, 31) == 0) begin
                    tgt_v[i] = int'($urandom_range(0, 2**GW - 1));
                end
            end
        end
        drive();
        model_cycle();
    endtask

    task automatic run_cycles(input int n, input bit random_en);
        for (int c = 0; c < n; c++) step_cycle(random_en);
    endtask

    task automatic do_reset(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rst   = 1'b1;
            req_v = '0;
            for (int i = 0; i < NREQ; i++) begin
                pend[i]   = 1'b0;
                ack_at[i] = -1;
            end
            drive();
            model_cycle();
        end
    endtask

    // Expected outputs for the current cycle are derived from the oldest
    // outstanding service; outside a service the sequencer must look idle.
    always @(negedge clk) begin
        svc_t e;
        int ec, eg, ea, es, eb, d, sg, n, k;
        ec = last_code; eg = 0; ea = 0; es = 0; eb = 0;
        if (rst_q) begin
            while (sb.size() > 0 && sb[0].latch < cyc) void'(sb.pop_front());
            last_code = RC;
            ec = RC;
        end else if (sb.size() > 0 && sb[0].latch < cyc) begin
            e  = sb[0];
            d  = (e.target > e.start) ? e.target - e.start : e.start - e.target;
            sg = (e.target > e.start) ? 1 : -1;
            n  = (cyc - e.latch) / RD;
            k  = (n < d) ? n : d;
            ec = e.start + sg * k;
            es = (n >= 1 && n <= d && ((cyc - e.latch) % RD) == 0) ? 1 : 0;
            eb = 1;
            if (cyc < e.ack)  eg = 1 << e.winner;
            if (cyc == e.ack) ea = 1 << e.winner;
            if (cyc >= e.ack) begin
                void'(sb.pop_front());
                last_code = e.target;
            end
        end
        for (int i = 0; i < NREQ; i++) if (ifc.ack[i]) ack_log.push_back(i);
        checkOutput("gain_code", int'(ifc.gain_code), ec);
        checkOutput("step",      int'(ifc.step),      es);
        checkOutput("busy",      int'(ifc.busy),      eb);
        checkOutput("grant",     int'(ifc.grant),     eg);
        checkOutput("ack",       int'(ifc.ack),       ea);
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            tgt_v[i]  = 0;
            pend[i]   = 1'b0;
            ack_at[i] = -1;
        end
        drive();

        $display("[TB] reset and idle");
        do_reset(3);
        run_cycles(20, 1'b0);

        $display("[TB] single request, zero delta");
        applyStimulus(1, 0);
        run_cycles(15, 1'b0);

        $display("[TB] ramp up 0 -> 3");
        applyStimulus(0, 3);
        run_cycles(20, 1'b0);

        $display("[TB] round-robin fairness");
        do_reset(2);
        ack_log.delete();
        sticky = 1'b1;
        applyStimulus(0, 5);
        applyStimulus(1, 9);
        applyStimulus(2, 2);
        applyStimulus(3, 7);
        run_cycles(110, 1'b0);
        for (int i = 0; i < 5; i++)
            checkOutput("rr_order", (i < ack_log.size()) ? ack_log[i] : -1, rr_exp[i]);
        sticky = 1'b0;

        $display("[TB] mid-service req drop and tgt change");
        do_reset(2);
        applyStimulus(2, 12);
        run_cycles(4, 1'b0);
        req_v[2] = 1'b0;
        tgt_v[2] = 1;
        run_cycles(40, 1'b0);

        $display("[TB] reset during ramp");
        applyStimulus(1, 10);
        run_cycles(12, 1'b0);
        do_reset(2);
        applyStimulus(1, 4);
        applyStimulus(3, 6);
        run_cycles(60, 1'b0);

        $display("[TB] randomized traffic");
        run_cycles(3000, 1'b1);
        run_cycles(300, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
